tbus_mem_responder: RTL and testbench
=====================================

# tbus_mem_responder

Responder end of the trinity bus (tbus): the memory-side slave that the memblock load/store initiator talks to. It accepts one request at a time (read, or write with a bit mask) through the `tbus_index_valid`/`tbus_index_ready` handshake. It services the request against an internal 64-bit-wide memory array after a fixed latency, then returns a one-cycle `tbus_operation_done` pulse with `tbus_read_data`. It stands in for the dcache/memory in core-level simulation and FPGA bring-up, and honours the memblock's `mem2dcache_flush` abort.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: log2 of the number of 64-bit words in the array.
- `LATENCY`, default 2, legal range 1..15: cycles from the accept edge to `tbus_operation_done`.

Ports:
- `clock`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tbus_index_valid`  in  1  request valid; the initiator holds it until accepted.
- `tbus_index_ready`  out  1  responder can accept a request.
- `tbus_index`  in  `RESULT_RANGE` (64)  byte address.
- `tbus_write_data`  in  `SRC_RANGE` (64)  write data, already lane-aligned.
- `tbus_write_mask`  in  64  per-bit write enable.
- `tbus_operation_type`  in  `TBUS_OPTYPE_RANGE`  `TBUS_READ` / `TBUS_WRITE`.
- `tbus_read_data`  out  `RESULT_RANGE`  full 64-bit word; valid in the done cycle.
- `tbus_operation_done`  out  1  one-cycle completion pulse.
- `flush`  in  1  abort request from the memblock (`mem2dcache_flush`).

## Operation
- States:
  - IDLE: ready = 1.
  - BUSY: latency countdown; ready = 0.
  - RESP: done = 1; ready = 0.
- Accept: `fire = tbus_index_valid & tbus_index_ready`. On `fire`, the responder latches:
  - word index = `tbus_index[DEPTH_LOG2+2:3]`; bits [2:0] and upper bits are ignored.
  - op type, write data, write mask.
  - counter = `LATENCY-1`.
- Transitions:
  - IDLE → RESP on `fire` when `LATENCY`=1.
  - IDLE → BUSY on `fire` when `LATENCY`≥2.
  - BUSY stays until counter reaches 1, then goes to RESP.
  - RESP → IDLE unconditionally.
- Commit happens on the edge entering RESP:
  - Write: `mem[w] <= (mem[w] & ~mask) | (data & mask)`; `rdata_q` is not changed.
  - Read: `rdata_q <= mem[w]`.
  - Any other op type: no array access; `rdata_q <= 0`.
- Flush:
  - A sticky `cancel` flag is set if `flush` is high in the accept cycle or in any BUSY cycle, including the commit cycle.
  - When cancelled: the write is suppressed, `rdata_q <= 0`, and done still pulses so the initiator leaves OUTSTANDING.
  - `cancel` clears in RESP.
  - `flush` in IDLE with no fire has no effect.
- The array is not reset. Reading a never-written word is undefined; benches write before reading.

## Timing
- Reset values:
  - `tbus_index_ready` = 1.
  - `tbus_operation_done` = 0.
  - `tbus_read_data` = 0.
  - state = IDLE, counter = 0, `cancel` = 0.
- `tbus_index_ready` is decoded directly from state (no combinational path from valid). `tbus_operation_done` and `tbus_read_data` are registered.
- If fire occurs in cycle T, done is high in exactly cycle T+`LATENCY` and data is valid in that cycle. The earliest next fire is cycle T+`LATENCY`+1.
- `tbus_read_data` holds its last value outside the done cycle.
- Read-after-write to the same word in back-to-back transactions returns the new data, because transactions are serialized.
- Reset asserted mid-transaction aborts immediately to the reset values with no done pulse. Any partially latched write is discarded.
- Valid asserted while ready is low is ignored and does not stall; the initiator keeps it held.

## Configuration
- `TBUS_RESP_RANDLAT_EN` defined:
  - An 8-bit Galois LFSR (seed 8'hA5 at reset, polynomial x^8+x^6+x^5+x^4+1) advances on every fire.
  - Effective latency = `LATENCY` + `lfsr[1:0]`, range `LATENCY`..`LATENCY`+3. The counter must be widened to hold this.
  - Used to stress initiator OUTSTANDING handling.
- Undefined: latency is exactly `LATENCY`, and no LFSR logic is present.

## Structure
- `TBUS_READ`, `TBUS_WRITE`, `TBUS_OPTYPE_RANGE`, `RESULT_RANGE`, `SRC_RANGE` come from the shared `defines.sv`. No new shared types are added.
- State encodings (IDLE/BUSY/RESP) are local parameters of the module.
- One sub-module, `tbus_resp_lfsr`, instantiated only under `TBUS_RESP_RANDLAT_EN`. Ports: clock, reset_n, advance, 8-bit value.
- The memory array is an inferred register array with a single read/write port.

## Test plan
- Reset, then WRITE addr 0x10, data 0x1122334455667788, mask all-ones; then READ 0x10. Read done must come exactly `LATENCY` cycles after its fire with data 0x1122334455667788; ready must be low between fire and done.
- Write 0xFF at byte offset 3 of addr 0x18 (data 0xFF<<24, mask 0xFF<<24) over an existing 0x0. Reading 0x18 must return 0x00000000FF000000; bytes outside the mask are unchanged.
- Hold valid continuously with 4 back-to-back READs, `LATENCY`=1. Fires must occur at cycles 0,2,4,6 and done at 1,3,5,7.
- Flush in the first BUSY cycle of a WRITE of 0xDEAD to 0x20 (prior content 0x5). Done still pulses, and a subsequent read of 0x20 returns 0x5. Flush during a read returns 0 with done.
- Deassert `reset_n` mid-BUSY. Outputs must return to ready=1, done=0, data=0 immediately with no later done pulse. A new read after reset completes normally.
- With `TBUS_RESP_RANDLAT_EN`, 64 reads must all complete with fire-to-done latency in [`LATENCY`, `LATENCY`+3], and the sequence of latencies must match the LFSR model.

Source files
------------

// File: rtl/tbus_mem_responder_pkg.sv
//------------------------------------------------------------------------------
// tbus_mem_responder_pkg
// Shared tbus widths, operation encodings and the latency-jitter LFSR helper
// used by the tbus memory responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package tbus_mem_responder_pkg;

  localparam int RESULT_W      = 64;
  localparam int SRC_W         = 64;
  localparam int TBUS_OPTYPE_W = 2;

  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'd1;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'd2;

  // Galois LFSR for x^8+x^6+x^5+x^4+1, right-shifting form
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {1'b0, cur[7:1]} ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tbus_resp_lfsr.sv
//------------------------------------------------------------------------------
// tbus_resp_lfsr
// 8-bit Galois LFSR that steps once per accepted request; its low bits add
// 0..3 cycles of extra latency to the tbus responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tbus_resp_lfsr
  import tbus_mem_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Step only when the responder accepts a request
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) lfsr_d = lfsr_step(lfsr_q);
  end

  // LFSR state register, reseeded on reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/tbus_mem_responder.sv
//------------------------------------------------------------------------------
// tbus_mem_responder
// Memory-side tbus slave: accepts one read/masked-write at a time, services it
// against a 64-bit-wide register array after a fixed latency and pulses done
// with the read data. A flush from the memblock cancels the request in flight
// while still completing the handshake.
// Optional feature macro: TBUS_RESP_RANDLAT_EN (adds 0..3 cycles of LFSR-driven
// latency jitter per request).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tbus_mem_responder
  import tbus_mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     tbus_index_valid,
  output logic                     tbus_index_ready,
  input  logic [RESULT_W-1:0]      tbus_index,
  input  logic [SRC_W-1:0]         tbus_write_data,
  input  logic [63:0]              tbus_write_mask,
  input  logic [TBUS_OPTYPE_W-1:0] tbus_operation_type,
  output logic [RESULT_W-1:0]      tbus_read_data,
  output logic                     tbus_operation_done,
  input  logic                     flush
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WORDS = 1 << DEPTH_LOG2;
`ifdef TBUS_RESP_RANDLAT_EN
  // LATENCY (max 15) plus up to 3 cycles of jitter needs a fifth bit
  localparam int CNT_W = 5;
`else
  localparam int CNT_W = 4;
`endif

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         lat_eff;
  logic                     cancel_q;
  logic [DEPTH_LOG2-1:0]    idx_q;
  logic [TBUS_OPTYPE_W-1:0] op_q;
  logic [SRC_W-1:0]         wdata_q;
  logic [63:0]              wmask_q;
  logic [RESULT_W-1:0]      rdata_q;
  logic                     done_q;
  logic [63:0]              mem [WORDS];

  logic                     fire;
  logic                     commit;
  logic                     cur_cancel;
  logic                     mem_we;
  logic [DEPTH_LOG2-1:0]    cur_idx;
  logic [TBUS_OPTYPE_W-1:0] cur_op;
  logic [SRC_W-1:0]         cur_wdata;
  logic [63:0]              cur_wmask;
  logic [63:0]              rd_word;
  logic                     unused_idx_bits;

  assign tbus_index_ready = (state_q == ST_IDLE);
  assign fire             = tbus_index_valid & tbus_index_ready;

  // Byte offset and bits above the array depth do not select a word
  assign unused_idx_bits = ^{tbus_index[RESULT_W-1:DEPTH_LOG2+3], tbus_index[2:0]};

`ifdef TBUS_RESP_RANDLAT_EN
  logic [7:0] lfsr_val;
  logic       unused_lfsr_bits;

  tbus_resp_lfsr u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .advance (fire),
    .value   (lfsr_val)
  );

  assign lat_eff          = CNT_W'(LATENCY) + CNT_W'(lfsr_val[1:0]);
  assign unused_lfsr_bits = ^lfsr_val[7:2];
`else
  assign lat_eff = CNT_W'(LATENCY);
`endif

  // With LATENCY=1 the commit edge is the accept edge, so the commit path
  // must see the live request rather than the latched copy.
  assign cur_idx    = (state_q == ST_IDLE) ? tbus_index[DEPTH_LOG2+2:3] : idx_q;
  assign cur_op     = (state_q == ST_IDLE) ? tbus_operation_type        : op_q;
  assign cur_wdata  = (state_q == ST_IDLE) ? tbus_write_data            : wdata_q;
  assign cur_wmask  = (state_q == ST_IDLE) ? tbus_write_mask            : wmask_q;
  assign cur_cancel = cancel_q | flush;
  assign rd_word    = mem[cur_idx];

  // Next state and latency countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          cnt_d   = lat_eff - CNT_W'(1);
          state_d = (lat_eff == CNT_W'(1)) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign commit = (state_q != ST_RESP) && (state_d == ST_RESP);
  // Reset gate keeps a request arriving during reset out of the unreset array
  assign mem_we = commit && !cur_cancel && (cur_op == TBUS_WRITE) && reset_n;

  // Control, request latch, cancel flag and registered response
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cancel_q <= 1'b0;
      idx_q    <= '0;
      op_q     <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= commit;
      if (fire) begin
        idx_q   <= tbus_index[DEPTH_LOG2+2:3];
        op_q    <= tbus_operation_type;
        wdata_q <= tbus_write_data;
        wmask_q <= tbus_write_mask;
      end
      if (fire)                              cancel_q <= flush;
      else if (state_q == ST_BUSY && flush)  cancel_q <= 1'b1;
      else if (state_q == ST_RESP)           cancel_q <= 1'b0;
      if (commit) begin
        if (cur_cancel)                rdata_q <= '0;
        else if (cur_op == TBUS_READ)  rdata_q <= rd_word;
        else if (cur_op != TBUS_WRITE) rdata_q <= '0;
      end
    end
  end

  // Single-port array: masked read-modify-write on the commit edge
  always_ff @(posedge clock) begin
    if (mem_we) mem[cur_idx] <= (rd_word & ~cur_wmask) | (cur_wdata & cur_wmask);
  end

  assign tbus_read_data      = rdata_q;
  assign tbus_operation_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tbus_mem_responder.sv
//------------------------------------------------------------------------------
// tb_tbus_mem_responder
// Self-checking bench for tbus_mem_responder: directed scenarios followed by
// randomized requests checked against a word-level memory/latency model.
// Optional feature macro: TBUS_RESP_RANDLAT_EN (model adds LFSR jitter).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_tbus_mem_responder;
  import tbus_mem_responder_pkg::*;

  localparam int DL2 = 10;
  localparam int LAT = 2;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid   = 1'b0;
  logic        flush   = 1'b0;
  logic        ready;
  logic        done;
  logic [63:0] index   = 64'h0;
  logic [63:0] wdata   = 64'h0;
  logic [63:0] wmask   = 64'h0;
  logic [1:0]  optype  = 2'd0;
  logic [63:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: word-addressed memory, last response data, jitter state
  logic [63:0] ref_mem [int];
  logic [63:0] ref_rdata = 64'h0;
  logic [7:0]  ref_lfsr  = 8'hA5;

  always #5 clock = ~clock;

  tbus_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .tbus_index_valid    (valid),
    .tbus_index_ready    (ready),
    .tbus_index          (index),
    .tbus_write_data     (wdata),
    .tbus_write_mask     (wmask),
    .tbus_operation_type (optype),
    .tbus_read_data      (rdata),
    .tbus_operation_done (done),
    .flush               (flush)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fire-to-done latency of the next accepted request
  function automatic int model_latency();
    int l;
    l = LAT;
`ifdef TBUS_RESP_RANDLAT_EN
    l = LAT + int'(ref_lfsr % 8'd4);
    if (ref_lfsr[0]) ref_lfsr = (ref_lfsr >> 1) ^ 8'hB8;
    else             ref_lfsr = ref_lfsr >> 1;
`endif
    return l;
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'((a >> 3) % (64'd1 << DL2));
  endfunction

  // One transaction starting at a negedge with the DUT idle. flush_at = -1 for
  // none, 0 for the accept cycle, k for the k-th cycle after acceptance.
  task automatic txn(input string tag, input logic [1:0] op, input logic [63:0] addr,
                     input logic [63:0] d, input logic [63:0] m, input int flush_at,
                     output logic [63:0] got);
    int          exp_lat, lat, w;
    logic [63:0] exp, old;
    bit          cancel, seen, ready_low;
    index = addr; wdata = d; wmask = m; optype = op;
    valid = 1'b1;
    flush = (flush_at == 0);
    @(posedge clock);
    exp_lat = model_latency();
    w       = word_of(addr);
    cancel  = (flush_at >= 0) && (flush_at < exp_lat);
    if (cancel) exp = 64'h0;
    else if (op == TBUS_READ) exp = ref_mem[w];
    else if (op == TBUS_WRITE) begin
      old      = ref_mem.exists(w) ? ref_mem[w] : 64'h0;
      ref_mem[w] = (old & ~m) | (d & m);
      exp      = ref_rdata;
    end else exp = 64'h0;
    ref_rdata = exp;
    seen = 1'b0; lat = 0; ready_low = 1'b1; got = 'x;
    for (int k = 1; k <= 24 && !seen; k++) begin
      @(negedge clock);
      if (k == 1) valid = 1'b0;
      if (ready) ready_low = 1'b0;
      if (done) begin
        seen = 1'b1; lat = k; got = rdata;
      end
      flush = !seen && (flush_at == k);
    end
    flush = 1'b0;
    check({tag, " done seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " lat range"}, 64'(lat >= LAT && lat <= LAT + 3), 64'd1);
    check({tag, " ready low"}, 64'(ready_low), 64'd1);
    check({tag, " rdata"}, got, exp);
    @(negedge clock);
    check({tag, " done pulse"}, 64'(done), 64'd0);
    check({tag, " ready back"}, 64'(ready), 64'd1);
    check({tag, " rdata hold"}, rdata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] g;
    logic [63:0] b2b_addr [4];
    logic [63:0] exp_data [4];
    int          exp_done [4];
    int          nf, nd, exp_fire, last_fire, l, ndone;
    logic [1:0]  op;
    logic [63:0] a, d, m;
    int          fa;

    // Reset values
    repeat (3) @(negedge clock);
    check("reset ready", 64'(ready), 64'd1);
    check("reset done", 64'(done), 64'd0);
    check("reset rdata", rdata, 64'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Full-word write then read
    txn("wr10", TBUS_WRITE, 64'h10, 64'h1122334455667788, '1, -1, g);
    txn("rd10", TBUS_READ, 64'h10, 64'h0, 64'h0, -1, g);
    check("rd10 value", g, 64'h1122334455667788);

    // Byte-lane masked write over zero
    txn("wr18 zero", TBUS_WRITE, 64'h18, 64'h0, '1, -1, g);
    txn("wr18 lane", TBUS_WRITE, 64'h18, 64'hFF << 24, 64'hFF << 24, -1, g);
    txn("rd18", TBUS_READ, 64'h18, 64'h0, 64'h0, -1, g);
    check("rd18 value", g, 64'h00000000FF000000);

    // Flush in first BUSY cycle suppresses the write; flush on a read gives 0
    txn("wr20 init", TBUS_WRITE, 64'h20, 64'h5, '1, -1, g);
    txn("wr20 flushed", TBUS_WRITE, 64'h20, 64'hDEAD, '1, 1, g);
    txn("rd20", TBUS_READ, 64'h20, 64'h0, 64'h0, -1, g);
    check("rd20 value", g, 64'h5);
    txn("rd10 flushed", TBUS_READ, 64'h10, 64'h0, 64'h0, 0, g);
    check("rd10 flushed value", g, 64'h0);

    // Flush while idle with no request is harmless
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    txn("rd10 after idle flush", TBUS_READ, 64'h10, 64'h0, 64'h0, -1, g);
    check("rd10 after idle flush value", g, 64'h1122334455667788);

    // Unknown operation type: no access, zero data
    txn("op3", 2'd3, 64'h10, 64'hFFFF, '1, -1, g);
    check("op3 value", g, 64'h0);

    // Back-to-back reads with valid held high throughout
    b2b_addr[0] = 64'h10; b2b_addr[1] = 64'h18;
    b2b_addr[2] = 64'h20; b2b_addr[3] = 64'h17;
    valid = 1'b1; optype = TBUS_READ; index = b2b_addr[0];
    nf = 0; nd = 0; exp_fire = 0; last_fire = -10;
    for (int c = 0; c < 100 && nd < 4; c++) begin
      if (c > 0) @(negedge clock);
      if (c == last_fire + 1) begin
        if (nf < 4) index = b2b_addr[nf];
        else        valid = 1'b0;
      end
      if (done) begin
        if (nd < nf) begin
          check("b2b done cycle", 64'(c), 64'(exp_done[nd]));
          check("b2b rdata", rdata, exp_data[nd]);
        end else check("b2b spurious done", 64'(1), 64'(0));
        nd++;
      end
      if (valid && ready) begin
        check("b2b fire cycle", 64'(c), 64'(exp_fire));
        l = model_latency();
        exp_done[nf] = c + l;
        exp_data[nf] = ref_mem[word_of(b2b_addr[nf])];
        ref_rdata    = exp_data[nf];
        exp_fire     = c + l + 1;
        last_fire    = c;
        nf++;
      end
    end
    valid = 1'b0;
    check("b2b fires", 64'(nf), 64'd4);
    check("b2b dones", 64'(nd), 64'd4);
    @(negedge clock);

    // Reset in the middle of a write: immediate abort, write discarded
    index = 64'h10; wdata = 64'hAAAA_BBBB_CCCC_DDDD; wmask = '1; optype = TBUS_WRITE;
    valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    valid   = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midreset ready", 64'(ready), 64'd1);
    check("midreset done", 64'(done), 64'd0);
    check("midreset rdata", rdata, 64'h0);
    ref_lfsr  = 8'hA5;
    ref_rdata = 64'h0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    check("midreset no done", 64'(ndone), 64'd0);
    txn("rd10 after reset", TBUS_READ, 64'h10, 64'h0, 64'h0, -1, g);
    check("rd10 after reset value", g, 64'h1122334455667788);

    // Randomized traffic over a small initialized window of words
    for (int w = 0; w < 16; w++) begin
      a = {$urandom, $urandom};
      a[DL2+2:3] = DL2'(w);
      txn("rand init", TBUS_WRITE, a, {$urandom, $urandom}, '1, -1, g);
    end
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 9))
        0:       op = 2'd0;
        1:       op = 2'd3;
        2, 3, 4: op = TBUS_WRITE;
        default: op = TBUS_READ;
      endcase
      a = {$urandom, $urandom};
      a[DL2+2:3] = DL2'($urandom_range(0, 15));
      d  = {$urandom, $urandom};
      m  = {$urandom, $urandom};
      fa = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LAT + 4)) : -1;
      txn("rand", op, a, d, m, fa, g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
